// File: rtl/senseedge_pkg.sv
// senseedge_pkg
// Shared definitions for the senseedge Wishbone master.
//   state_t          : FSM state encoding (IDLE, BUS, RESP)
//   TIMEOUT_DEFAULT  : default bus-wait limit, in BUS cycles
//   TMO_CNT_W        : width of the timeout counter (covers limits up to 1023)
//   tmo_last()       : counter value on which the timeout fires
package senseedge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int TIMEOUT_DEFAULT = 64;
  localparam int TMO_CNT_W       = 10;

  // The counter starts at 0 on the first BUS cycle, so the last allowed
  // cycle is the one where the count reads timeout-1.
  function automatic logic [TMO_CNT_W-1:0] tmo_last(input int timeout);
    return TMO_CNT_W'(timeout - 1);
  endfunction

endpackage

// File: rtl/senseedge_wb_master.sv
// senseedge_wb_master
// Turns a valid/ready command stream into single Wishbone classic bus
// cycles and returns each result on a valid/ready response stream.
// Exactly one transaction is in flight at a time.
//
// Ports
//   wb_clk_i, wb_rst_ni      : clock, synchronous active-low reset
//   cmd_valid_i/cmd_ready_o  : command handshake (ready only while idle)
//   cmd_we_i, cmd_adr_i,
//   cmd_dat_i, cmd_sel_i     : command payload (write flag, byte address,
//                              write data, byte selects)
//   rsp_valid_o/rsp_ready_i  : response handshake
//   rsp_dat_o                : read data (0 for writes and errors)
//   rsp_err_o, rsp_tmo_o     : bus error / timeout flags
//   wbm_*                    : Wishbone classic master interface
module senseedge_wb_master
  import senseedge_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,

  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [AW-1:0]   cmd_adr_i,
  input  logic [DW-1:0]   cmd_dat_i,
  input  logic [DW/8-1:0] cmd_sel_i,

  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_dat_o,
  output logic            rsp_err_o,
  output logic            rsp_tmo_o,

  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  output logic [DW/8-1:0] wbm_sel_o,
  input  logic [DW-1:0]   wbm_dat_i,
  input  logic            wbm_ack_i,
  input  logic            wbm_err_i
);

  localparam logic [TMO_CNT_W-1:0] TMO_LAST = tmo_last(TIMEOUT);

  state_t               state;
  logic [TMO_CNT_W-1:0] tmo_cnt;

  logic                 bus_done;
  logic                 tmo_hit;
  logic                 nxt_err;
  logic                 nxt_tmo;
  logic [DW-1:0]        nxt_dat;

  // Ready depends on state alone so an upstream source never sees a
  // combinational path from its own valid back to ready.
  assign cmd_ready_o = (state == ST_IDLE);

  // Outcome of the current BUS cycle. A slave answer always beats the
  // timeout, and err beats ack when both arrive together. These terms are
  // only consumed in BUS, so stray ack/err in other states have no effect.
  always_comb begin
    tmo_hit  = (tmo_cnt == TMO_LAST);
    bus_done = 1'b0;
    nxt_err  = 1'b0;
    nxt_tmo  = 1'b0;
    nxt_dat  = '0;
    if (wbm_err_i) begin
      bus_done = 1'b1;
      nxt_err  = 1'b1;
    end else if (wbm_ack_i) begin
      bus_done = 1'b1;
      nxt_dat  = wbm_we_o ? '0 : wbm_dat_i;
    end else if (tmo_hit) begin
      bus_done = 1'b1;
      nxt_err  = 1'b1;
      nxt_tmo  = 1'b1;
    end
  end

  // Main FSM. All bus and response outputs are registers, so cyc/stb rise
  // the cycle after acceptance and fall the cycle after the slave answers.
  // Reset clears the bus controls on the same edge and drops any pending
  // response, so an interrupted transaction never produces a result.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state       <= ST_IDLE;
      tmo_cnt     <= '0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      wbm_sel_o   <= '0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
      rsp_tmo_o   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= cmd_we_i;
            wbm_adr_o <= cmd_adr_i;
            // Reads keep the write-data bus quiet.
            wbm_dat_o <= cmd_we_i ? cmd_dat_i : '0;
            wbm_sel_o <= cmd_sel_i;
            tmo_cnt   <= '0;
            state     <= ST_BUS;
          end
        end

        ST_BUS: begin
          if (bus_done) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
            wbm_sel_o   <= '0;
            rsp_valid_o <= 1'b1;
            rsp_dat_o   <= nxt_dat;
            rsp_err_o   <= nxt_err;
            rsp_tmo_o   <= nxt_tmo;
            tmo_cnt     <= '0;
            state       <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_CNT_W'(1);
          end
        end

        ST_RESP: begin
          // Payload registers are left untouched here, so they hold
          // steady for as long as the consumer stalls.
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_senseedge_wb_master.sv
// tb_senseedge_wb_master
// Directed bench for senseedge_wb_master with TIMEOUT=16. A table of
// transactions (command, slave behaviour, expected response) is run in a
// loop, followed by hand-written sequences for back-pressure, stray slave
// responses and reset in the middle of a transaction. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_senseedge_wb_master;

  localparam int TMO = 16;

  typedef enum logic [1:0] {
    ACT_NONE = 2'd0,
    ACT_ACK  = 2'd1,
    ACT_ERR  = 2'd2,
    ACT_BOTH = 2'd3
  } act_t;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    int          wait_cycles;
    act_t        act;
    logic [31:0] rdat;
    logic        exp_err;
    logic        exp_tmo;
    logic [31:0] exp_dat;
    int          exp_stb;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        rsp_tmo;
  logic        wbm_cyc;
  logic        wbm_stb;
  logic        wbm_we;
  logic [31:0] wbm_adr;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack;
  logic        wbm_err;

  int checks = 0;
  int errors = 0;

  vec_t vecs[7];

  senseedge_wb_master #(
    .AW(32),
    .DW(32),
    .TIMEOUT(TMO)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_we_i   (cmd_we),
    .cmd_adr_i  (cmd_adr),
    .cmd_dat_i  (cmd_dat),
    .cmd_sel_i  (cmd_sel),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_dat_o  (rsp_dat),
    .rsp_err_o  (rsp_err),
    .rsp_tmo_o  (rsp_tmo),
    .wbm_cyc_o  (wbm_cyc),
    .wbm_stb_o  (wbm_stb),
    .wbm_we_o   (wbm_we),
    .wbm_adr_o  (wbm_adr),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_sel_o  (wbm_sel),
    .wbm_dat_i  (wbm_dat_i),
    .wbm_ack_i  (wbm_ack),
    .wbm_err_i  (wbm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports a mismatch on a single line.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Runs one transaction from the table: issues the command, plays the
  // slave (ack/err on the chosen stb cycle), checks bus stability and the
  // response, and optionally consumes the response.
  task automatic applyStimulus(input vec_t v, input string name, input bit release_rsp);
    int          stb_cycles;
    int          guard;
    bit          stable;
    logic [31:0] exp_wdat;
    exp_wdat   = v.we ? v.wdat : 32'h0;
    stb_cycles = 0;
    guard      = 0;
    stable     = 1'b1;

    cmd_valid = 1'b1;
    cmd_we    = v.we;
    cmd_adr   = v.adr;
    cmd_dat   = v.wdat;
    cmd_sel   = v.sel;
    checkOutput({name, " cmd_ready idle"}, {31'h0, cmd_ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_adr   = 32'hFFFF_FFFF;
    cmd_dat   = 32'hFFFF_FFFF;

    while (rsp_valid !== 1'b1 && guard < 40) begin
      if (wbm_stb === 1'b1) begin
        stb_cycles++;
        if (wbm_cyc !== 1'b1 || wbm_adr !== v.adr || wbm_we !== v.we ||
            wbm_sel !== v.sel || wbm_dat_o !== exp_wdat || cmd_ready !== 1'b0)
          stable = 1'b0;
      end
      wbm_dat_i = 32'h5A5A_5A5A;
      if (stb_cycles == v.wait_cycles + 1 && v.act != ACT_NONE) begin
        wbm_ack   = (v.act == ACT_ACK) || (v.act == ACT_BOTH);
        wbm_err   = (v.act == ACT_ERR) || (v.act == ACT_BOTH);
        wbm_dat_i = v.rdat;
      end
      @(posedge clk);
      @(negedge clk);
      wbm_ack = 1'b0;
      wbm_err = 1'b0;
      guard++;
    end

    checkOutput({name, " stb cycles"}, stb_cycles, v.exp_stb);
    checkOutput({name, " bus stable"}, {31'h0, stable}, 32'h1);
    checkOutput({name, " rsp_valid"}, {31'h0, rsp_valid}, 32'h1);
    checkOutput({name, " rsp_err"}, {31'h0, rsp_err}, {31'h0, v.exp_err});
    checkOutput({name, " rsp_tmo"}, {31'h0, rsp_tmo}, {31'h0, v.exp_tmo});
    checkOutput({name, " rsp_dat"}, rsp_dat, v.exp_dat);
    checkOutput({name, " cyc/stb low"}, {30'h0, wbm_cyc, wbm_stb}, 32'h0);

    if (release_rsp) begin
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      checkOutput({name, " rsp_valid cleared"}, {31'h0, rsp_valid}, 32'h0);
      checkOutput({name, " back to idle"}, {31'h0, cmd_ready}, 32'h1);
    end
  endtask

  initial begin
    bit ok;

    //            we    adr           wdat          sel   wait act       rdat          err   tmo   dat           stb
    vecs[0] = '{1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 0,  ACT_ACK,  32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0,         1};
    vecs[1] = '{1'b0, 32'h3000_0010, 32'h0000_0000, 4'hF, 3,  ACT_ACK,  32'h1234_5678, 1'b0, 1'b0, 32'h1234_5678, 4};
    vecs[2] = '{1'b0, 32'h3000_0020, 32'h1111_2222, 4'hF, 1,  ACT_ERR,  32'hAAAA_5555, 1'b1, 1'b0, 32'h0,         2};
    vecs[3] = '{1'b1, 32'h4000_0000, 32'h0BAD_F00D, 4'h3, 0,  ACT_BOTH, 32'h7777_7777, 1'b1, 1'b0, 32'h0,         1};
    vecs[4] = '{1'b0, 32'h5000_0008, 32'h0000_0000, 4'hF, 0,  ACT_NONE, 32'h0,         1'b1, 1'b1, 32'h0,         16};
    vecs[5] = '{1'b0, 32'h0000_0001, 32'h0000_0000, 4'h1, 15, ACT_ACK,  32'hCAFE_F00D, 1'b0, 1'b0, 32'hCAFE_F00D, 16};
    vecs[6] = '{1'b1, 32'h6000_00FC, 32'h8765_4321, 4'hC, 15, ACT_ERR,  32'h0,         1'b1, 1'b0, 32'h0,         16};

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = 32'h0;
    cmd_dat   = 32'h0;
    cmd_sel   = 4'h0;
    rsp_ready = 1'b0;
    wbm_dat_i = 32'h0;
    wbm_ack   = 1'b0;
    wbm_err   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset wbm ctrl", {29'h0, wbm_cyc, wbm_stb, wbm_we}, 32'h0);
    checkOutput("reset wbm adr", wbm_adr, 32'h0);
    checkOutput("reset wbm dat", wbm_dat_o, 32'h0);
    checkOutput("reset wbm sel", {28'h0, wbm_sel}, 32'h0);
    checkOutput("reset rsp flags", {29'h0, rsp_valid, rsp_err, rsp_tmo}, 32'h0);
    checkOutput("reset rsp dat", rsp_dat, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle cmd_ready", {31'h0, cmd_ready}, 32'h1);

    // Table-driven transactions
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i), 1'b1);
    end

    // Stray ack/err while idle must not start anything
    wbm_ack = 1'b1;
    wbm_err = 1'b1;
    ok = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid !== 1'b0 || wbm_cyc !== 1'b0 || cmd_ready !== 1'b1) ok = 1'b0;
    end
    wbm_ack = 1'b0;
    wbm_err = 1'b0;
    checkOutput("idle ack ignored", {31'h0, ok}, 32'h1);

    // Back-pressure: response held, new command must wait
    applyStimulus(vecs[1], "bp", 1'b0);
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_adr   = 32'h7000_0000;
    cmd_dat   = 32'h1357_9BDF;
    cmd_sel   = 4'hF;
    ok = 1'b1;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (cmd_ready !== 1'b0 || wbm_stb !== 1'b0 || wbm_cyc !== 1'b0 ||
          rsp_valid !== 1'b1 || rsp_dat !== 32'h1234_5678 ||
          rsp_err !== 1'b0 || rsp_tmo !== 1'b0) ok = 1'b0;
    end
    checkOutput("backpressure hold", {31'h0, ok}, 32'h1);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("backpressure release", {30'h0, rsp_valid, cmd_ready}, 32'h1);

    // Reset in the middle of a bus wait
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_adr   = 32'h3000_0040;
    cmd_sel   = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("pre-reset stb", {31'h0, wbm_stb}, 32'h1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset drops cyc/stb", {30'h0, wbm_cyc, wbm_stb}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (TMO + 4) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid !== 1'b0 || wbm_cyc !== 1'b0) ok = 1'b0;
    end
    checkOutput("no rsp after bus reset", {31'h0, ok}, 32'h1);
    applyStimulus(vecs[0], "after bus reset", 1'b1);

    // Reset while a response is pending
    applyStimulus(vecs[2], "resp reset", 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || cmd_ready !== 1'b1) ok = 1'b0;
    end
    checkOutput("rsp discarded by reset", {31'h0, ok}, 32'h1);
    applyStimulus(vecs[5], "after resp reset", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/senseedge_wb_master.md
SENSEEDGE_WB_MASTER -- requirements
Module: senseedge_wb_master

Interface
REQ-001 Parameter AW, default 32, Wishbone address width.
REQ-002 Parameter DW, default 32, Wishbone data width.
REQ-003 Parameter TIMEOUT, default 64, max cycles waiting for ack/err before abort (range 2..1023).
REQ-004 wb_clk_i  in  1  sole clock; all logic rising-edge.
REQ-005 wb_rst_ni  in  1  reset, synchronous, active-low.
REQ-006 cmd_valid_i  in  1  request present.
REQ-007 cmd_ready_o  out  1  request accepted this cycle when both high.
REQ-008 cmd_we_i  in  1  1 = write, 0 = read.
REQ-009 cmd_adr_i  in  AW  byte address.
REQ-010 cmd_dat_i  in  DW  write data.
REQ-011 cmd_sel_i  in  DW/8  byte selects.
REQ-012 rsp_valid_o  out  1  response present.
REQ-013 rsp_ready_i  in  1  response consumed when both high.
REQ-014 rsp_dat_o  out  DW  read data (0 for writes and errors).
REQ-015 rsp_err_o  out  1  bus error or timeout.
REQ-016 rsp_tmo_o  out  1  abort due to timeout.
REQ-017 wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone classic master controls.
REQ-018 wbm_adr_o  out  AW; wbm_dat_o  out  DW; wbm_sel_o  out  DW/8.
REQ-019 wbm_dat_i  in  DW; wbm_ack_i  in  1; wbm_err_i  in  1  slave responses.

Function
REQ-020 FSM states IDLE, BUS, RESP; exactly one transaction outstanding at a time.
REQ-021 cmd_ready_o SHALL equal 1 only in IDLE, combinationally from state.
REQ-022 On accept: latch we/adr/dat/sel into output registers, go BUS; wbm_cyc_o=wbm_stb_o=1 from next cycle.
REQ-023 In BUS, cyc/stb/adr/dat/sel/we SHALL remain stable until ack, err or timeout is sampled.
REQ-024 ack sampled in BUS: capture wbm_dat_i (reads) to rsp_dat_o, rsp_err_o=0, go RESP; cyc/stb low next cycle.
REQ-025 err sampled in BUS: rsp_dat_o=0, rsp_err_o=1, rsp_tmo_o=0, go RESP.
REQ-026 ack and err same cycle: err wins.
REQ-027 Timeout counter clears on entry to BUS, increments each BUS cycle; at TIMEOUT-1 without ack/err: rsp_err_o=1, rsp_tmo_o=1, rsp_dat_o=0, go RESP.
REQ-028 ack/err arriving on the same cycle the timeout fires SHALL take priority over timeout.
REQ-029 ack/err while not in BUS SHALL be ignored.
REQ-030 RESP: rsp_valid_o=1, payload stable until rsp_ready_i; then IDLE. rsp_valid_o=0 outside RESP.
REQ-031 Minimum latency: accept at cycle N, stb at N+1, ack at N+1, rsp_valid_o at N+2; next accept no earlier than N+3 (rsp_ready_i held 1).
REQ-032 Write data: wbm_dat_o drives latched cmd_dat_i for writes; holds 0 for reads.

Reset
REQ-033 With wb_rst_ni=0 at an edge: state IDLE, all wbm_* outputs 0, rsp_valid_o/rsp_err_o/rsp_tmo_o 0, rsp_dat_o 0, timeout counter 0.
REQ-034 Reset during BUS SHALL drop cyc/stb on the same edge; no response is ever issued for the aborted transaction.
REQ-035 Reset during RESP SHALL discard the pending response.

Structure
REQ-036 State encoding and default TIMEOUT constant SHALL live in the shared senseedge_pkg.
REQ-037 Single module; no sub-module (counter and FSM inline).

Verification
REQ-038 Write adr=0x3000_0004 dat=0xDEAD_BEEF sel=0xF, slave acks 1 cycle after stb -> one stb cycle with those values, rsp_valid with err=0, dat=0.
REQ-039 Read adr=0x3000_0010, slave returns 0x1234_5678 with ack after 3 wait cycles -> rsp_dat_o=0x1234_5678, err=0; adr stable all 4 stb cycles.
REQ-040 Slave never responds, TIMEOUT=16 -> cyc drops after exactly 16 BUS cycles, rsp_err_o=1, rsp_tmo_o=1.
REQ-041 ack and err asserted together -> rsp_err_o=1, rsp_tmo_o=0, rsp_dat_o=0.
REQ-042 rsp_ready_i held 0 for 10 cycles with cmd_valid_i=1 -> cmd_ready_o stays 0, no new stb, response payload unchanged.
REQ-043 wb_rst_ni pulled low during BUS wait -> cyc/stb 0 on that edge, no rsp_valid_o after release, next command completes normally.
